t2mi_ts_mux: RTL and testbench

T2MI_TS_MUX -- requirements
Module: t2mi_ts_mux

---
 rtl/t2mi_ts_mux.sv | 225 ++++++++++++++++++++++
 tb/tb_t2mi_ts_mux.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t2mi_ts_mux.sv
// Round-robin multiplexer that wraps per-channel T2-MI payloads into 188-byte
// TS packets (or null packets when idle) on a CE-gated byte clock.
module t2mi_ts_mux #(
  parameter int N_CH      = 2,
  parameter int NULL_FILL = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic [N_CH-1:0]      CH_REQ,
  input  logic [8*N_CH-1:0]    CH_PTR,
  input  logic [8*N_CH-1:0]    CH_DATA,
  input  logic [13*N_CH-1:0]   CH_PID,
  output logic [N_CH-1:0]      CH_RD,
  output logic [7:0]           DATA_OUT,
  output logic                 ENA_OUT,
  output logic                 PSYNC_OUT
);

  typedef enum logic [2:0] {
    S_ARB = 3'd0,
    S_HDR = 3'd1,
    S_PTR = 3'd2,
    S_PAY = 3'd3,
    S_NUL = 3'd4
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [7:0]   idx_r, idx_nxt_s;
  logic [7:0]   data_r, data_nxt_s;
  logic         ena_r, ena_nxt_s;
  logic         psync_r, psync_nxt_s;
  logic [2:0]   grant_r;
  logic [2:0]   last_grant_r;
  logic [7:0]   ptr_r;
  logic [12:0]  pid_r;
  logic [3:0]   cc_r [8];

  // Inputs padded to the 8-channel maximum so selects never run out of range
  logic [7:0]   req8_s;
  logic [63:0]  ptr_pad_s;
  logic [63:0]  data_pad_s;
  logic [103:0] pid_pad_s;

  logic         arb_found_s;
  logic [2:0]   arb_sel_s;
  logic [3:0]   cand_s;
  logic [7:0]   sel_ptr_s;
  logic [12:0]  sel_pid_s;
  logic [7:0]   head_s;
  logic [3:0]   cc_grant_s;
  logic         pusi_s;
  logic         grab_s;
  logic         cc_inc_s;
  logic [7:0]   rd8_s;

  assign req8_s     = 8'(CH_REQ);
  assign ptr_pad_s  = 64'(CH_PTR);
  assign data_pad_s = 64'(CH_DATA);
  assign pid_pad_s  = 104'(CH_PID);
  assign cc_grant_s = cc_r[grant_r];
  assign pusi_s     = (ptr_r != 8'hFF);

  assign CH_RD     = rd8_s[N_CH-1:0];
  assign DATA_OUT  = data_r;
  assign ENA_OUT   = ena_r;
  assign PSYNC_OUT = psync_r;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    arb_found_s = 1'b0;
    arb_sel_s   = 3'd0;
    cand_s      = 4'd0;
    for (int k = 1; k <= N_CH; k++) begin
      cand_s = {1'b0, last_grant_r} + 4'(k);
      cand_s = (cand_s >= 4'(N_CH)) ? (cand_s - 4'(N_CH)) : cand_s;
      if (!arb_found_s && req8_s[cand_s[2:0]]) begin
        arb_found_s = 1'b1;
        arb_sel_s   = cand_s[2:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Per-channel field selection for the arbitration winner and the active grant
  always_comb begin
    sel_ptr_s = 8'h00;
    sel_pid_s = 13'h0000;
    head_s    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (arb_sel_s == 3'(i)) begin
        sel_ptr_s = ptr_pad_s[i*8 +: 8];
        sel_pid_s = pid_pad_s[i*13 +: 13];
      end else begin
        sel_ptr_s = sel_ptr_s;
      end
      if (grant_r == 3'(i)) begin
        head_s = data_pad_s[i*8 +: 8];
      end else begin
        head_s = head_s;
      end
    end
  end

  // Next-state, output byte and pop strobe for the current CE slot
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = data_r;
    ena_nxt_s   = 1'b0;
    psync_nxt_s = psync_r;
    grab_s      = 1'b0;
    cc_inc_s    = 1'b0;
    rd8_s       = 8'h00;
    if (CE) begin
      ena_nxt_s   = 1'b1;
      psync_nxt_s = 1'b0;
      idx_nxt_s   = idx_r + 8'd1;
      case (state_r)
        S_ARB: begin
          data_nxt_s  = 8'h47;
          psync_nxt_s = 1'b1;
          if (arb_found_s) begin
            grab_s      = 1'b1;
            state_nxt_s = S_HDR;
          end else if (NULL_FILL != 0) begin
            state_nxt_s = S_NUL;
          end else begin
            // Idle without fill: stay parked at index 0 and retry next slot
            data_nxt_s  = data_r;
            ena_nxt_s   = 1'b0;
            psync_nxt_s = 1'b0;
            idx_nxt_s   = 8'd0;
          end
        end
        S_HDR: begin
          case (idx_r)
            8'd1:    data_nxt_s = {1'b0, pusi_s, 1'b0, pid_r[12:8]};
            8'd2:    data_nxt_s = pid_r[7:0];
            8'd3: begin
              data_nxt_s  = {4'b0001, cc_grant_s};
              state_nxt_s = pusi_s ? S_PTR : S_PAY;
            end
            default: begin
              state_nxt_s = S_ARB;
              idx_nxt_s   = 8'd0;
              ena_nxt_s   = 1'b0;
            end
          endcase
        end
        S_PTR: begin
          data_nxt_s  = ptr_r;
          state_nxt_s = S_PAY;
        end
        S_PAY: begin
          data_nxt_s = head_s;
          rd8_s      = 8'd1 << grant_r;
          if (idx_r == 8'd187) begin
            cc_inc_s    = 1'b1;
            idx_nxt_s   = 8'd0;
            state_nxt_s = S_ARB;
          end else begin
            state_nxt_s = S_PAY;
          end
        end
        S_NUL: begin
          case (idx_r)
            8'd1:    data_nxt_s = 8'h1F;
            8'd2:    data_nxt_s = 8'hFF;
            8'd3:    data_nxt_s = 8'h10;
            default: data_nxt_s = 8'hFF;
          endcase
          if (idx_r == 8'd187) begin
            idx_nxt_s   = 8'd0;
            state_nxt_s = S_ARB;
          end else begin
            state_nxt_s = S_NUL;
          end
        end
        default: begin
          state_nxt_s = S_ARB;
          idx_nxt_s   = 8'd0;
          ena_nxt_s   = 1'b0;
        end
      endcase
    end else begin
      ena_nxt_s = 1'b0;
    end
  end

  // State, output and per-channel continuity registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= S_ARB;
      idx_r        <= 8'd0;
      data_r       <= 8'h00;
      ena_r        <= 1'b0;
      psync_r      <= 1'b0;
      grant_r      <= 3'd0;
      last_grant_r <= 3'(N_CH - 1);
      ptr_r        <= 8'h00;
      pid_r        <= 13'h0000;
      for (int i = 0; i < 8; i++) begin
        cc_r[i] <= 4'd0;
      end
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      data_r  <= data_nxt_s;
      ena_r   <= ena_nxt_s;
      psync_r <= psync_nxt_s;
      if (grab_s) begin
        grant_r      <= arb_sel_s;
        last_grant_r <= arb_sel_s;
        ptr_r        <= sel_ptr_s;
        pid_r        <= sel_pid_s;
      end
      if (cc_inc_s) begin
        cc_r[grant_r] <= cc_r[grant_r] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_t2mi_ts_mux.sv
// Scoreboard bench for t2mi_ts_mux: a byte-source model per channel feeds the
// DUT, and every expected output byte is queued ahead and compared on output.
module tb_t2mi_ts_mux;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [1:0]  ch_req;
  logic [15:0] ch_ptr;
  logic [15:0] ch_data;
  logic [25:0] ch_pid;
  logic [1:0]  ch_rd;
  logic [7:0]  data;
  logic        ena;
  logic        psync;
  logic [1:0]  rd2;
  logic [7:0]  data2;
  logic        ena2;
  logic        psync2;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          src_cnt [2] = '{0, 0};
  int          pop_cnt [2] = '{0, 0};
  int          cnt_m   [2];
  logic [3:0]  cc_m    [2];
  logic [8:0]  exp_q   [$];
  logic        idle2;
  int          base0;
  int          base1;

  t2mi_ts_mux #(.N_CH(2), .NULL_FILL(1)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .CH_REQ(ch_req), .CH_PTR(ch_ptr),
    .CH_DATA(ch_data), .CH_PID(ch_pid), .CH_RD(ch_rd), .DATA_OUT(data),
    .ENA_OUT(ena), .PSYNC_OUT(psync)
  );

  t2mi_ts_mux #(.N_CH(2), .NULL_FILL(0)) dut_nf0 (
    .CLK(clk), .RST(rst), .CE(ce), .CH_REQ(ch_req), .CH_PTR(ch_ptr),
    .CH_DATA(ch_data), .CH_PID(ch_pid), .CH_RD(rd2), .DATA_OUT(data2),
    .ENA_OUT(ena2), .PSYNC_OUT(psync2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(input int c, input int n);
    return 8'(n * 7 + c * 100 + 3);
  endfunction

  assign ch_data = {data_of(1, src_cnt[1]), data_of(0, src_cnt[0])};

  // Show-ahead sources: head advances on each pop, flushed by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      src_cnt[0] <= 0;
      src_cnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ch_rd[i]) src_cnt[i] <= src_cnt[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && ch_rd[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int c, input logic [12:0] pid, input logic [7:0] ptr);
    int n;
    exp_q.push_back({1'b1, 8'h47});
    exp_q.push_back({1'b0, 1'b0, (ptr != 8'hFF), 1'b0, pid[12:8]});
    exp_q.push_back({1'b0, pid[7:0]});
    exp_q.push_back({1'b0, 4'h1, cc_m[c]});
    if (ptr != 8'hFF) begin
      exp_q.push_back({1'b0, ptr});
      n = 183;
    end else begin
      n = 184;
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({1'b0, data_of(c, cnt_m[c])});
      cnt_m[c]++;
    end
    cc_m[c] = cc_m[c] + 4'd1;
  endtask

  task automatic push_null();
    exp_q.push_back({1'b1, 8'h47});
    exp_q.push_back({1'b0, 8'h1F});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h10});
    for (int k = 0; k < 184; k++) exp_q.push_back({1'b0, 8'hFF});
  endtask

  // One clock slot: called just after a falling edge with ce already set
  task automatic cycle();
    logic       ce_now;
    logic [8:0] e;
    ce_now = ce;
    #1;
    if (!ce_now) check("rd_when_ce0", 16'(ch_rd), 16'd0);
    @(posedge clk);
    @(negedge clk);
    if (!ce_now) check("ena_when_ce0", 16'(ena), 16'd0);
    if (ena) begin
      if (exp_q.size() == 0) begin
        check("extra_byte_ena", 16'(ena), 16'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", 16'(data), 16'(e[7:0]));
        check("psync_out", 16'(psync), 16'(e[8]));
      end
    end
    if (idle2) begin
      check("nf0_ena", 16'(ena2), 16'd0);
      check("nf0_rd", 16'(rd2), 16'd0);
    end
  endtask

  task automatic run_q(input bit toggle, input int budget);
    int n;
    bit ph;
    n  = 0;
    ph = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      ce = toggle ? ph : 1'b1;
      ph = ~ph;
      cycle();
      n++;
    end
    ce = 1'b0;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) begin
      ce = 1'b1;
      cycle();
    end
  endtask

  initial begin
    rst    = 1'b1;
    ce     = 1'b0;
    ch_req = 2'b00;
    ch_ptr = {8'hFF, 8'hFF};
    ch_pid = {13'h1001, 13'h1000};
    idle2  = 1'b0;
    cnt_m  = '{0, 0};
    cc_m   = '{4'd0, 4'd0};
    repeat (3) @(negedge clk);
    check("rst_data", 16'(data), 16'h00);
    check("rst_ena", 16'(ena), 16'd0);
    check("rst_psync", 16'(psync), 16'd0);
    check("rst_rd", 16'(ch_rd), 16'd0);
    check("rst_ena_nf0", 16'(ena2), 16'd0);
    rst = 1'b0;

    // Alternating grant on two always-ready channels, CC 0,1,2 per PID
    ch_req = 2'b11;
    base0 = pop_cnt[0]; base1 = pop_cnt[1];
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 13'h1000, 8'hFF);
      push_pkt(1, 13'h1001, 8'hFF);
    end
    run_q(1'b0, 1200);
    check("pops_alt_ch0", 16'(pop_cnt[0] - base0), 16'd552);
    check("pops_alt_ch1", 16'(pop_cnt[1] - base1), 16'd552);

    // Pointer field present: 183 payload pops
    ch_req = 2'b01;
    ch_ptr[7:0] = 8'h05;
    base0 = pop_cnt[0]; base1 = pop_cnt[1];
    push_pkt(0, 13'h1000, 8'h05);
    run_q(1'b0, 400);
    check("pops_pusi_ch0", 16'(pop_cnt[0] - base0), 16'd183);
    check("pops_pusi_ch1", 16'(pop_cnt[1] - base1), 16'd0);

    // Idle: null packet on the fill instance, silence on the other
    ch_req = 2'b00;
    idle2  = 1'b1;
    base0 = pop_cnt[0]; base1 = pop_cnt[1];
    push_null();
    run_q(1'b0, 400);
    idle2 = 1'b0;
    check("pops_null_ch0", 16'(pop_cnt[0] - base0), 16'd0);
    check("pops_null_ch1", 16'(pop_cnt[1] - base1), 16'd0);

    // Null packet leaves last grant at ch0, so ch1 wins next
    ch_req = 2'b11;
    ch_ptr = {8'hFF, 8'hFF};
    base1 = pop_cnt[1];
    push_pkt(1, 13'h1001, 8'hFF);
    run_q(1'b0, 400);
    check("pops_after_null_ch1", 16'(pop_cnt[1] - base1), 16'd184);

    // CE toggling 1,0,1,0 must give the same byte stream
    base0 = pop_cnt[0];
    push_pkt(0, 13'h1000, 8'hFF);
    run_q(1'b1, 800);
    check("pops_toggle_ch0", 16'(pop_cnt[0] - base0), 16'd184);

    // Reset at byte index 100 of a ch0 packet
    ch_req = 2'b01;
    base0 = pop_cnt[0];
    push_pkt(0, 13'h1000, 8'hFF);
    run_n(100);
    rst = 1'b1;
    #1;
    check("midrst_data", 16'(data), 16'h00);
    check("midrst_ena", 16'(ena), 16'd0);
    check("midrst_psync", 16'(psync), 16'd0);
    check("midrst_rd", 16'(ch_rd), 16'd0);
    check("pops_before_rst", 16'(pop_cnt[0] - base0), 16'd96);
    ce = 1'b0;
    exp_q.delete();
    cnt_m = '{0, 0};
    cc_m  = '{4'd0, 4'd0};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First packet after reset goes to ch0 with CC=0, then 16 more to wrap CC
    ch_req = 2'b11;
    base0 = pop_cnt[0]; base1 = pop_cnt[1];
    push_pkt(0, 13'h1000, 8'hFF);
    run_q(1'b0, 400);
    ch_req = 2'b01;
    for (int p = 0; p < 16; p++) push_pkt(0, 13'h1000, 8'hFF);
    run_q(1'b0, 3300);
    check("pops_wrap_ch0", 16'(pop_cnt[0] - base0), 16'd3128);
    check("pops_wrap_ch1", 16'(pop_cnt[1] - base1), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
